// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: word/register widths, writeback-source encoding and
// the memory-stage FSM state encoding.
package cpu_types_pkg;

    localparam int unsigned WordW = 32;
    localparam int unsigned RegW  = 5;

    typedef logic [WordW-1:0] word_t;
    typedef logic [RegW-1:0]  regbits_t;

    typedef enum logic [1:0] {
        WdatAlu = 2'd0,
        WdatMem = 2'd1,
        WdatLui = 2'd2,
        WdatNpc = 2'd3
    } wdatsel_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StHalted = 2'd2
    } mem_state_t;

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline latch: loads when enabled, clear has priority over load and
// forces a bubble (all fields zero).
module memwb_reg #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              wen_i,
    input  logic [REG_W-1:0]  wsel_i,
    input  logic [WORD_W-1:0] wdat_i,
    input  logic [WORD_W-1:0] npc_i,
    input  logic [WORD_W-1:0] imem_i,
    output logic              wen_o,
    output logic [REG_W-1:0]  wsel_o,
    output logic [WORD_W-1:0] wdat_o,
    output logic [WORD_W-1:0] npc_o,
    output logic [WORD_W-1:0] imem_o
);

    logic              wen_q;
    logic [REG_W-1:0]  wsel_q;
    logic [WORD_W-1:0] wdat_q;
    logic [WORD_W-1:0] npc_q;
    logic [WORD_W-1:0] imem_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wen_q  <= 1'b0;
            wsel_q <= '0;
            wdat_q <= '0;
            npc_q  <= '0;
            imem_q <= '0;
        end else if (en_i) begin
            if (clr_i) begin
                wen_q  <= 1'b0;
                wsel_q <= '0;
                wdat_q <= '0;
                npc_q  <= '0;
                imem_q <= '0;
            end else begin
                wen_q  <= wen_i;
                wsel_q <= wsel_i;
                wdat_q <= wdat_i;
                npc_q  <= npc_i;
                imem_q <= imem_i;
            end
        end
    end

    assign wen_o  = wen_q;
    assign wsel_o = wsel_q;
    assign wdat_o = wdat_q;
    assign npc_o  = npc_q;
    assign imem_o = imem_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues data-cache requests, stalls until dhit,
// resolves writeback data into MEM/WB, and owns sticky halt and stall counter.
module mem_stage #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    input  logic              dREN_in,
    input  logic              dWEN_in,
    input  logic              WEN_in,
    input  logic              halt_in,
    input  logic [REG_W-1:0]  wsel_in,
    input  logic [1:0]        wdatsel_in,
    input  logic [WORD_W-1:0] port_o_in,
    input  logic [WORD_W-1:0] rdat2_in,
    input  logic [WORD_W-1:0] lui_word_in,
    input  logic [WORD_W-1:0] npc_in,
    input  logic [WORD_W-1:0] imemload_in,
    input  logic              flush,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              WEN_out,
    output logic [REG_W-1:0]  wsel_out,
    output logic [WORD_W-1:0] wdat_out,
    output logic [WORD_W-1:0] npc_out,
    output logic [WORD_W-1:0] imemload_out,
    output logic              halt_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    import cpu_types_pkg::*;

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              halted;
    logic              memop;
    logic              stall;
    logic              bubble;
    logic              halt_capture;
    logic [WORD_W-1:0] wdat_mux;

    assign halted = (state_q == StHalted);
    assign memop  = in_valid & (dREN_in | dWEN_in) & ~halted;

    // Requests and stall are gated by nRST so they drop the instant reset asserts.
    assign dmemWEN   = nRST & memop & dWEN_in;
    assign dmemREN   = nRST & memop & dREN_in & ~dWEN_in;
    assign stall     = nRST & memop & ~dhit;
    assign mem_stall = stall;
    assign dmemaddr  = port_o_in;
    assign dmemstore = rdat2_in;

    assign bubble       = flush | ~in_valid | halted;
    assign halt_capture = ~stall & ~bubble & halt_in;

    always_comb begin
        wdat_mux = port_o_in;
        unique case (wdatsel_t'(wdatsel_in))
            WdatAlu: wdat_mux = port_o_in;
            WdatMem: wdat_mux = dmemload;
            WdatLui: wdat_mux = lui_word_in;
            WdatNpc: wdat_mux = npc_in;
            default: wdat_mux = port_o_in;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (memop && !dhit) state_d = StWait;
            StWait:   if (dhit) state_d = StIdle;
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
        if (halt_capture) begin
            state_d = StHalted;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign halt_out  = halted;
    assign stall_cnt = cnt_q;

    memwb_reg #(
        .WORD_W (WORD_W),
        .REG_W  (REG_W)
    ) u_memwb (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .en_i   (~stall),
        .clr_i  (bubble),
        .wen_i  (WEN_in),
        .wsel_i (wsel_in),
        .wdat_i (wdat_mux),
        .npc_i  (npc_in),
        .imem_i (imemload_in),
        .wen_o  (WEN_out),
        .wsel_o (wsel_out),
        .wdat_o (wdat_out),
        .npc_o  (npc_out),
        .imem_o (imemload_out)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized run
// against a transaction-level model of MEM/WB, requests and stall counting.
module tb_mem_stage;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned SAT_W  = 3;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              in_valid, dREN_in, dWEN_in, WEN_in, halt_in;
    logic [REG_W-1:0]  wsel_in;
    logic [1:0]        wdatsel_in;
    logic [WORD_W-1:0] port_o_in, rdat2_in, lui_word_in, npc_in, imemload_in;
    logic              flush, dhit;
    logic [WORD_W-1:0] dmemload;

    logic              dmemREN, dmemWEN, mem_stall, WEN_out, halt_out;
    logic [WORD_W-1:0] dmemaddr, dmemstore, wdat_out, npc_out, imemload_out;
    logic [REG_W-1:0]  wsel_out;
    logic [CNT_W-1:0]  stall_cnt;

    logic              s_dmemREN, s_dmemWEN, s_mem_stall, s_WEN_out, s_halt_out;
    logic [WORD_W-1:0] s_dmemaddr, s_dmemstore, s_wdat_out, s_npc_out, s_imemload_out;
    logic [REG_W-1:0]  s_wsel_out;
    logic [SAT_W-1:0]  s_stall_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [CNT_W-1:0]  exp_cnt;
    logic              exp_wen;
    logic [REG_W-1:0]  exp_wsel;
    logic [WORD_W-1:0] exp_wdat, exp_npc, exp_imem;

    always #5 CLK = ~CLK;

    mem_stage #(.WORD_W(WORD_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
        .WEN_in(WEN_in), .halt_in(halt_in), .wsel_in(wsel_in), .wdatsel_in(wdatsel_in),
        .port_o_in(port_o_in), .rdat2_in(rdat2_in), .lui_word_in(lui_word_in),
        .npc_in(npc_in), .imemload_in(imemload_in), .flush(flush), .dhit(dhit),
        .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_stall(mem_stall), .WEN_out(WEN_out),
        .wsel_out(wsel_out), .wdat_out(wdat_out), .npc_out(npc_out),
        .imemload_out(imemload_out), .halt_out(halt_out), .stall_cnt(stall_cnt)
    );

    mem_stage #(.WORD_W(WORD_W), .REG_W(REG_W), .CNT_W(SAT_W)) dut_sat (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
        .WEN_in(WEN_in), .halt_in(halt_in), .wsel_in(wsel_in), .wdatsel_in(wdatsel_in),
        .port_o_in(port_o_in), .rdat2_in(rdat2_in), .lui_word_in(lui_word_in),
        .npc_in(npc_in), .imemload_in(imemload_in), .flush(flush), .dhit(dhit),
        .dmemload(dmemload), .dmemREN(s_dmemREN), .dmemWEN(s_dmemWEN),
        .dmemaddr(s_dmemaddr), .dmemstore(s_dmemstore), .mem_stall(s_mem_stall),
        .WEN_out(s_WEN_out), .wsel_out(s_wsel_out), .wdat_out(s_wdat_out),
        .npc_out(s_npc_out), .imemload_out(s_imemload_out), .halt_out(s_halt_out),
        .stall_cnt(s_stall_cnt)
    );

    function automatic logic [WORD_W-1:0] pick_wdat(input logic [1:0] sel,
        input logic [WORD_W-1:0] alu, mem, lui, npc);
        logic [WORD_W-1:0] src [4];
        src[0] = alu;
        src[1] = mem;
        src[2] = lui;
        src[3] = npc;
        return src[sel];
    endfunction

    task automatic set_op(input logic v, input logic ren, input logic wen, input logic rwen,
        input logic hlt, input logic [REG_W-1:0] ws, input logic [1:0] sel,
        input logic [WORD_W-1:0] alu, input logic [WORD_W-1:0] st,
        input logic [WORD_W-1:0] lui, input logic [WORD_W-1:0] npc,
        input logic [WORD_W-1:0] imem);
        in_valid    = v;
        dREN_in     = ren;
        dWEN_in     = wen;
        WEN_in      = rwen;
        halt_in     = hlt;
        wsel_in     = ws;
        wdatsel_in  = sel;
        port_o_in   = alu;
        rdat2_in    = st;
        lui_word_in = lui;
        npc_in      = npc;
        imemload_in = imem;
    endtask

    task automatic set_idle();
        set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 2'd0, '0, '0, '0, '0, '0);
        flush = 1'b0;
        dhit  = 1'b0;
    endtask

    task automatic model_clear();
        exp_wen  = 1'b0;
        exp_wsel = '0;
        exp_wdat = '0;
        exp_npc  = '0;
        exp_imem = '0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 2'd1, 32'h40, '0, '0, '0, '0);
        dhit = 1'b0;
        flush = 1'b0;
        dmemload = '0;
        #12;
        checks++;
        if (dmemREN !== 1'b0 || dmemWEN !== 1'b0 || mem_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_req: REN=%b WEN=%b stall=%b, want 0 0 0",
                dmemREN, dmemWEN, mem_stall);
        end
        checks++;
        if ({WEN_out, wsel_out, wdat_out, npc_out, imemload_out, halt_out} !== '0
            || stall_cnt !== '0) begin
            failures++;
            $display("FAIL reset_regs: wen=%b wsel=%0d wdat=%h halt=%b cnt=%0d, want all 0",
                WEN_out, wsel_out, wdat_out, halt_out, stall_cnt);
        end
        @(negedge CLK);
        set_idle();
        nRST = 1'b1;
        exp_cnt = '0;
        model_clear();
    endtask

    task automatic test_load_hit();
        @(negedge CLK);
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 2'd1, 32'h100, '0, '0, 32'h8, 32'h8c450000);
        dhit = 1'b1;
        dmemload = 32'hDEADBEEF;
        #1;
        checks++;
        if (dmemREN !== 1'b1 || dmemWEN !== 1'b0 || mem_stall !== 1'b0
            || dmemaddr !== 32'h100) begin
            failures++;
            $display("FAIL load_hit_req: REN=%b WEN=%b stall=%b addr=%h, want 1 0 0 100",
                dmemREN, dmemWEN, mem_stall, dmemaddr);
        end
        @(posedge CLK); #1;
        checks++;
        if (WEN_out !== 1'b1 || wsel_out !== 5'd5 || wdat_out !== 32'hDEADBEEF
            || stall_cnt !== '0) begin
            failures++;
            $display("FAIL load_hit_wb: wen=%b wsel=%0d wdat=%h cnt=%0d, want 1 5 deadbeef 0",
                WEN_out, wsel_out, wdat_out, stall_cnt);
        end
        exp_wen = 1'b1; exp_wsel = 5'd5; exp_wdat = 32'hDEADBEEF;
        exp_npc = 32'h8; exp_imem = 32'h8c450000;
    endtask

    task automatic test_store_miss();
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 2'd0, 32'h200, 32'h1234, '0,
                32'hC, 32'hac470000);
            dhit = (c == 3);
            #1;
            checks++;
            if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dmemstore !== 32'h1234
                || dmemaddr !== 32'h200 || mem_stall !== (c != 3)) begin
                failures++;
                $display("FAIL store_miss_req c=%0d: WEN=%b REN=%b st=%h stall=%b, want 1 0 1234 %b",
                    c, dmemWEN, dmemREN, dmemstore, mem_stall, c != 3);
            end
            @(posedge CLK); #1;
            if (c != 3) begin
                exp_cnt++;
            end else begin
                exp_wen = 1'b0; exp_wsel = 5'd7; exp_wdat = 32'h200;
                exp_npc = 32'hC; exp_imem = 32'hac470000;
            end
            checks++;
            if ({WEN_out, wsel_out, wdat_out, npc_out, imemload_out}
                !== {exp_wen, exp_wsel, exp_wdat, exp_npc, exp_imem}
                || stall_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL store_miss_wb c=%0d: wen=%b wsel=%0d wdat=%h cnt=%0d, want %b %0d %h %0d",
                    c, WEN_out, wsel_out, wdat_out, stall_cnt, exp_wen, exp_wsel, exp_wdat,
                    exp_cnt);
            end
        end
        checks++;
        if (stall_cnt !== 32'd3) begin
            failures++;
            $display("FAIL store_miss_cnt: cnt=%0d, want 3", stall_cnt);
        end
    endtask

    task automatic test_nonmem();
        logic [1:0]        sels [2];
        logic [WORD_W-1:0] want [2];
        sels[0] = 2'd2; want[0] = 32'hABCD0000;
        sels[1] = 2'd3; want[1] = 32'h44;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, sels[i], 32'h55, '0, 32'hABCD0000,
                32'h44, 32'h3c01abcd);
            dhit = 1'b0;
            #1;
            checks++;
            if (dmemREN !== 1'b0 || dmemWEN !== 1'b0 || mem_stall !== 1'b0) begin
                failures++;
                $display("FAIL nonmem_req sel=%0d: REN=%b WEN=%b stall=%b, want 0 0 0",
                    sels[i], dmemREN, dmemWEN, mem_stall);
            end
            @(posedge CLK); #1;
            checks++;
            if (WEN_out !== 1'b1 || wdat_out !== want[i] || wsel_out !== 5'd9) begin
                failures++;
                $display("FAIL nonmem_wb sel=%0d: wen=%b wdat=%h wsel=%0d, want 1 %h 9",
                    sels[i], WEN_out, wdat_out, wsel_out, want[i]);
            end
        end
        exp_wen = 1'b1; exp_wsel = 5'd9; exp_wdat = 32'h44; exp_npc = 32'h44;
        exp_imem = 32'h3c01abcd;
    endtask

    task automatic test_flush();
        @(negedge CLK);
        set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 2'd0, 32'h77, '0, '0, 32'h10, 32'h1);
        flush = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (WEN_out !== 1'b0 || wdat_out !== '0 || wsel_out !== '0) begin
            failures++;
            $display("FAIL flush_alu: wen=%b wdat=%h wsel=%0d, want 0 0 0",
                WEN_out, wdat_out, wsel_out);
        end
        model_clear();
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd12, 2'd1, 32'h300, '0, '0, 32'h20,
                32'h8c0c0300);
            flush = (c != 2);
            dhit = (c == 2);
            dmemload = 32'hCAFEF00D;
            @(posedge CLK); #1;
            if (c != 2) begin
                exp_cnt++;
            end else begin
                exp_wen = 1'b1; exp_wsel = 5'd12; exp_wdat = 32'hCAFEF00D;
                exp_npc = 32'h20; exp_imem = 32'h8c0c0300;
            end
            checks++;
            if ({WEN_out, wsel_out, wdat_out, npc_out, imemload_out}
                !== {exp_wen, exp_wsel, exp_wdat, exp_npc, exp_imem}
                || stall_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL flush_stall c=%0d: wen=%b wsel=%0d wdat=%h cnt=%0d, want %b %0d %h %0d",
                    c, WEN_out, wsel_out, wdat_out, stall_cnt, exp_wen, exp_wsel, exp_wdat,
                    exp_cnt);
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int unsigned       kind, lat;
            logic              v, ren, wen, rwen, fl, memop_m;
            logic [REG_W-1:0]  ws;
            logic [1:0]        sel;
            logic [WORD_W-1:0] alu, st, lui, npc, imem, ld;
            logic [SAT_W-1:0]  exp_sat;
            kind = $urandom_range(0, 5);
            v    = (kind != 5);
            wen  = (kind == 1) || (kind == 5 && $urandom_range(0, 1) == 1);
            ren  = (kind == 0) || (kind != 2 && $urandom_range(0, 1) == 1);
            if (kind >= 2 && kind <= 4) begin
                wen = 1'b0;
                ren = 1'b0;
            end
            rwen = 1'($urandom_range(0, 1));
            ws   = REG_W'($urandom);
            sel  = 2'($urandom_range(0, 3));
            alu  = $urandom; st = $urandom; lui = $urandom; npc = $urandom; imem = $urandom;
            memop_m = v && (ren || wen);
            lat = memop_m ? $urandom_range(0, 3) : 0;
            for (int c = 0; c <= int'(lat); c++) begin
                @(negedge CLK);
                set_op(v, ren, wen, rwen, 1'b0, ws, sel, alu, st, lui, npc, imem);
                ld = $urandom;
                dmemload = ld;
                dhit = (c == int'(lat)) ? (memop_m ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
                fl = ($urandom_range(0, 4) == 0);
                flush = fl;
                #1;
                checks++;
                if (dmemREN !== (memop_m && ren && !wen) || dmemWEN !== (memop_m && wen)
                    || mem_stall !== (c != int'(lat))) begin
                    failures++;
                    $display("FAIL rand_req n=%0d c=%0d: REN=%b WEN=%b stall=%b, want %b %b %b",
                        n, c, dmemREN, dmemWEN, mem_stall, memop_m && ren && !wen,
                        memop_m && wen, c != int'(lat));
                end
                @(posedge CLK); #1;
                if (c != int'(lat)) begin
                    exp_cnt++;
                end else if (fl || !v) begin
                    model_clear();
                end else begin
                    exp_wen = rwen; exp_wsel = ws; exp_wdat = pick_wdat(sel, alu, ld, lui, npc);
                    exp_npc = npc; exp_imem = imem;
                end
                exp_sat = (exp_cnt > 7) ? 3'd7 : exp_cnt[2:0];
                checks++;
                if ({WEN_out, wsel_out, wdat_out, npc_out, imemload_out}
                    !== {exp_wen, exp_wsel, exp_wdat, exp_npc, exp_imem}
                    || stall_cnt !== exp_cnt || s_stall_cnt !== exp_sat) begin
                    failures++;
                    $display("FAIL rand_wb n=%0d c=%0d: wen=%b wsel=%0d wdat=%h npc=%h cnt=%0d sat=%0d, want %b %0d %h %h %0d %0d",
                        n, c, WEN_out, wsel_out, wdat_out, npc_out, stall_cnt, s_stall_cnt,
                        exp_wen, exp_wsel, exp_wdat, exp_npc, exp_cnt, exp_sat);
                end
            end
        end
        @(negedge CLK);
        set_idle();
    endtask

    task automatic test_reset_mid_miss();
        @(negedge CLK);
        set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 2'd1, 32'h400, '0, '0, 32'h30, 32'h2);
        dhit = 1'b0;
        @(negedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        checks++;
        if (dmemREN !== 1'b0 || mem_stall !== 1'b0 || stall_cnt !== '0 || halt_out !== 1'b0
            || {WEN_out, wsel_out, wdat_out, npc_out, imemload_out} !== '0) begin
            failures++;
            $display("FAIL reset_mid_miss: REN=%b stall=%b cnt=%0d wen=%b wdat=%h, want all 0",
                dmemREN, mem_stall, stall_cnt, WEN_out, wdat_out);
        end
        @(negedge CLK);
        set_idle();
        nRST = 1'b1;
        exp_cnt = '0;
        model_clear();
        @(negedge CLK);
        set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 2'd0, 32'h99, '0, '0, 32'h34, 32'h3);
        @(posedge CLK); #1;
        checks++;
        if (WEN_out !== 1'b1 || wdat_out !== 32'h99 || stall_cnt !== '0) begin
            failures++;
            $display("FAIL post_reset_op: wen=%b wdat=%h cnt=%0d, want 1 99 0",
                WEN_out, wdat_out, stall_cnt);
        end
    endtask

    task automatic test_halt();
        @(negedge CLK);
        set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, 2'd0, '0, '0, '0, 32'h50, 32'hfc000000);
        flush = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (halt_out !== 1'b0) begin
            failures++;
            $display("FAIL halt_flushed: halt_out=%b, want 0", halt_out);
        end
        @(negedge CLK);
        set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 2'd0, 32'h5, '0, '0, 32'h54, 32'hfc000000);
        flush = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (halt_out !== 1'b1 || WEN_out !== 1'b1 || wdat_out !== 32'h5) begin
            failures++;
            $display("FAIL halt_set: halt=%b wen=%b wdat=%h, want 1 1 5",
                halt_out, WEN_out, wdat_out);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            set_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 2'd1, 32'h500, '0, '0, 32'h58, 32'h4);
            dhit = 1'b0;
            #1;
            checks++;
            if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
                failures++;
                $display("FAIL halted_req: REN=%b stall=%b, want 0 0", dmemREN, mem_stall);
            end
            @(posedge CLK); #1;
            checks++;
            if (WEN_out !== 1'b0 || halt_out !== 1'b1 || stall_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL halted_wb: wen=%b halt=%b cnt=%0d, want 0 1 %0d",
                    WEN_out, halt_out, stall_cnt, exp_cnt);
            end
        end
        @(negedge CLK);
        set_idle();
        nRST = 1'b0;
        #1;
        checks++;
        if (halt_out !== 1'b0) begin
            failures++;
            $display("FAIL halt_reset: halt_out=%b, want 0", halt_out);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_hit();
        test_store_miss();
        test_nonmem();
        test_flush();
        test_random();
        test_reset_mid_miss();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline: consumes the EX/MEM latch outputs, issues the data-cache request and holds the pipeline until dhit.
- Resolves the writeback data and registers the MEM/WB latch that feeds the writeback mux and the register file.
- Owns the sticky halt and a saturating data-stall performance counter.

Parameters:
- WORD_W, 32, datapath word width
- REG_W, 5, register-select width
- CNT_W, 32, stall-counter width

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- in_valid  in  1  EX/MEM holds a real instruction; 0 = bubble
- dREN_in  in  1  load
- dWEN_in  in  1  store
- WEN_in  in  1  register write enable
- halt_in  in  1  halt instruction
- wsel_in  in  REG_W  destination register
- wdatsel_in  in  2  writeback source: 0 ALU, 1 MEM, 2 LUI, 3 NPC
- port_o_in  in  WORD_W  ALU result, also the memory address
- rdat2_in  in  WORD_W  store data
- lui_word_in  in  WORD_W  LUI result
- npc_in  in  WORD_W  PC+4
- imemload_in  in  WORD_W  instruction, for trace
- flush  in  1  load a bubble into MEM/WB
- dhit  in  1  cache completes the current request
- dmemload  in  WORD_W  load data, valid when dhit
- dmemREN  out  1  data read request
- dmemWEN  out  1  data write request
- dmemaddr  out  WORD_W  request address
- dmemstore  out  WORD_W  store data
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- WEN_out  out  1  MEM/WB register write
- wsel_out  out  REG_W  MEM/WB destination
- wdat_out  out  WORD_W  MEM/WB resolved write data
- npc_out  out  WORD_W  MEM/WB PC+4
- imemload_out  out  WORD_W  MEM/WB instruction
- halt_out  out  1  sticky halt
- stall_cnt  out  CNT_W  stall-cycle counter

Behaviour:
- Reset: asynchronous. State goes to IDLE. All MEM/WB outputs, halt_out and stall_cnt are 0. dmemREN, dmemWEN and mem_stall are 0 while nRST is low; an in-flight request is abandoned.
- Definitions:
  - memop = in_valid & (dREN_in | dWEN_in) & state != HALTED.
  - dmemWEN = memop & dWEN_in.
  - dmemREN = memop & dREN_in & ~dWEN_in. Store wins if both are set.
  - dmemaddr = port_o_in; dmemstore = rdat2_in. Both are combinational and held stable by upstream during a stall.
- mem_stall = memop & ~dhit (combinational).
  - A 0-wait hit gives no stall.
  - An N-cycle miss stalls for N cycles.
- FSM states: IDLE, WAIT, HALTED.
  - IDLE -> WAIT: memop & ~dhit.
  - WAIT -> IDLE: dhit.
  - WAIT remains WAIT while ~dhit. The request stays asserted.
  - Any state -> HALTED when a valid halt is captured into MEM/WB. HALTED exits only on reset.
- MEM/WB capture, on the rising edge when ~mem_stall:
  - Priority: flush, then capture, then bubble.
  - flush: WEN_out = 0; the other data fields go to 0.
  - Capture (in_valid): WEN_out = WEN_in, wsel_out, npc_out, imemload_out.
  - wdat_out by wdatsel_in: ALU gives port_o_in; MEM gives dmemload sampled in the dhit cycle; LUI gives lui_word_in; NPC gives npc_in.
  - in_valid = 0: WEN_out = 0.
- While mem_stall = 1, MEM/WB holds its value and flush is ignored. The hazard unit must not flush a stalled stage.
- Writes to wsel 0 pass through; the register file discards them.
- halt_out is set when a valid halt_in is captured (not flushed). It then stays 1.
  - In HALTED: no requests are issued and MEM/WB loads only bubbles.
- stall_cnt: +1 each cycle mem_stall = 1. It saturates at all-ones and does not wrap.
- dhit while no request is asserted is ignored.
- Latency: one clock from the EX/MEM value to the MEM/WB value, plus the miss cycles.

Decomposition:
- Shared cpu_types package holds:
  - word_t and regbits_t
  - the wdatsel encoding enum (ALU/MEM/LUI/NPC)
  - the mem_state_t enum (IDLE/WAIT/HALTED)
- Natural sub-module: memwb_reg, the MEM/WB pipeline latch with enable and flush.
- The FSM, request logic, write-data mux and counter stay in mem_stage.

Test Plan:
- Load with 0-wait hit: dREN_in=1, port_o_in=0x100, wdatsel=MEM, wsel=5, dhit=1 same cycle, dmemload=0xDEADBEEF -> dmemREN=1, mem_stall=0; next edge WEN_out=1, wsel_out=5, wdat_out=0xDEADBEEF; stall_cnt=0.
- Store with 3-cycle miss: dWEN_in=1, rdat2_in=0x1234, dhit asserted on the 4th cycle -> dmemWEN=1 and mem_stall=1 for 3 cycles, MEM/WB held; stall_cnt=3; state returns to IDLE.
- Non-memory op: wdatsel=LUI, lui_word_in=0xABCD0000 -> no request, wdat_out=0xABCD0000 after one edge; wdatsel=NPC, npc_in=0x44 -> wdat_out=0x44.
- Flush: flush=1 with a valid ALU op, not stalled -> WEN_out=0. Flush during a miss stall -> ignored; the load completes normally on dhit.
- Halt: halt_in=1 valid -> halt_out=1. A later load -> dmemREN=0, WEN_out=0. halt_out stays 1 until nRST.
- Reset mid-miss: nRST low while in WAIT -> dmemREN=0 and mem_stall=0 immediately; all outputs 0; state IDLE after release.
